// File: rtl/systolic_pe_v2_if.sv
// rtl/systolic_pe_v2_if.sv - operand, drain-chain and status bundle for one systolic PE
//
// Signals (slave = the PE, master = whoever drives it):
//   fire, clr          master->PE  operand pair valid / start new tile
//   in_w, in_a         master->PE  weight / activation operands (DATA_W)
//   out_f              PE->master  fire delayed one cycle for the neighbour
//   out_w, out_a       PE->master  operands captured on an accepted fire
//   drain              master->PE  request to shift the accumulator out
//   psum_in, _vld      master->PE  upstream drain-chain word (ACC_W)
//   psum_out, _vld     PE->master  downstream drain-chain word (ACC_W)
//   busy               PE->master  high while draining
//   ovf                PE->master  sticky accumulator overflow
interface systolic_pe_v2_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic              fire;
    logic              clr;
    logic [DATA_W-1:0] in_w;
    logic [DATA_W-1:0] in_a;
    logic              out_f;
    logic [DATA_W-1:0] out_w;
    logic [DATA_W-1:0] out_a;
    logic              drain;
    logic [ACC_W-1:0]  psum_in;
    logic              psum_in_vld;
    logic [ACC_W-1:0]  psum_out;
    logic              psum_out_vld;
    logic              busy;
    logic              ovf;

    modport master (
        output fire, clr, in_w, in_a, drain, psum_in, psum_in_vld,
        input  out_f, out_w, out_a, psum_out, psum_out_vld, busy, ovf
    );

    modport slave (
        input  fire, clr, in_w, in_a, drain, psum_in, psum_in_vld,
        output out_f, out_w, out_a, psum_out, psum_out_vld, busy, ovf
    );
endinterface

// File: rtl/systolic_pe_v2.sv
// rtl/systolic_pe_v2.sv - output-stationary MAC processing element with serial drain chain
//
// Parameters:
//   DATA_W    operand width
//   ACC_W     accumulator width, must be >= 2*DATA_W
//   SIGNED    1: two's complement operands/accumulator, 0: unsigned
//   CHAIN_POS number of PEs upstream on the drain chain (0 = chain head)
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous reset, active high
//   pe   systolic_pe_v2_if.slave: operands in/out, drain chain, busy, ovf
// Build option:
//   SYSTOLA_PE_SATURATE_EN  when defined the accumulator clamps at its range
//                           limits instead of wrapping; ovf flags every clamp.
module systolic_pe_v2 #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 20,
    parameter int SIGNED    = 0,
    parameter int CHAIN_POS = 0
) (
    input logic            clk,
    input logic            rst,
    systolic_pe_v2_if.slave pe
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PROD_W    = 2 * DATA_W;
    localparam int EXT_W     = ACC_W - PROD_W;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam int CNT_W     = (CHAIN_POS < 1) ? 1 : $clog2(CHAIN_POS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_POS);

    logic [1:0]        state;
    logic [ACC_W-1:0]  acc;
    logic              ovf_q;
    logic [CNT_W-1:0]  fwd_cnt;
    logic              out_f_q;
    logic [DATA_W-1:0] out_w_q;
    logic [DATA_W-1:0] out_a_q;
    logic [ACC_W-1:0]  psum_q;
    logic              psum_vld_q;

    // Operands are widened to the product width so that a plain multiply
    // yields the correct low 2*DATA_W bits for both signed and unsigned data.
    logic              w_sx;
    logic              a_sx;
    logic [PROD_W-1:0] w_ext;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] prod;
    logic              prod_sx;
    logic [ACC_W-1:0]  prod_ext;

    assign w_sx    = IS_SIGNED & pe.in_w[DATA_W-1];
    assign a_sx    = IS_SIGNED & pe.in_a[DATA_W-1];
    assign w_ext   = {{DATA_W{w_sx}}, pe.in_w};
    assign a_ext   = {{DATA_W{a_sx}}, pe.in_a};
    assign prod    = w_ext * a_ext;
    assign prod_sx = IS_SIGNED & prod[PROD_W-1];

    generate
        if (EXT_W > 0) begin : g_ext
            assign prod_ext = {{EXT_W{prod_sx}}, prod};
        end else begin : g_noext
            assign prod_ext = prod;
        end
    endgenerate

    // Accumulate; a clr-qualified fire restarts the tile from the product.
    logic              fire_ok;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  sum;
    logic              carry;
    logic              sgn_ovf;
    logic              wrapped;
    logic [ACC_W-1:0]  mac_val;
    logic [ACC_W-1:0]  acc_mac;
    logic              ovf_mac;

    assign fire_ok = pe.fire & (state != ST_DRAIN);
    assign base    = pe.clr ? '0 : acc;
    assign {carry, sum} = {1'b0, base} + {1'b0, prod_ext};

    // Signed overflow: both addends share a sign the result does not.
    assign sgn_ovf = (base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != base[ACC_W-1]);
    assign wrapped = IS_SIGNED ? sgn_ovf : carry;

`ifdef SYSTOLA_PE_SATURATE_EN
    logic [ACC_W-1:0] clamp;
    // A signed overflow can only happen away from zero in the direction of
    // base's sign, so base's sign picks the rail.
    assign clamp   = IS_SIGNED ? (base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                : {1'b0, {(ACC_W-1){1'b1}}})
                               : {ACC_W{1'b1}};
    assign mac_val = wrapped ? clamp : sum;
`else
    assign mac_val = sum;
`endif

    // A product always fits in ACC_W, so clr+fire can never overflow and
    // simply restarts the sticky flag.
    assign acc_mac = fire_ok ? mac_val : acc;
    assign ovf_mac = fire_ok ? ((ovf_q & ~pe.clr) | wrapped) : ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            ovf_q      <= 1'b0;
            fwd_cnt    <= '0;
            out_f_q    <= 1'b0;
            out_w_q    <= '0;
            out_a_q    <= '0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
        end else begin
            out_f_q <= fire_ok;
            ovf_q   <= ovf_mac;
            if (fire_ok) begin
                out_w_q <= pe.in_w;
                out_a_q <= pe.in_a;
            end

            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (pe.drain) begin
                        // Snapshot includes any MAC of this same cycle; the
                        // accumulator is free once its value sits in psum_out.
                        state      <= ST_DRAIN;
                        psum_q     <= acc_mac;
                        psum_vld_q <= 1'b1;
                        acc        <= '0;
                        fwd_cnt    <= '0;
                    end else begin
                        acc <= acc_mac;
                        if (fire_ok) begin
                            state <= ST_ACCUM;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (fwd_cnt == CNT_LAST) begin
                        // All upstream words have passed through.
                        state      <= ST_IDLE;
                        psum_vld_q <= 1'b0;
                        fwd_cnt    <= '0;
                    end else begin
                        psum_q     <= pe.psum_in;
                        psum_vld_q <= pe.psum_in_vld;
                        if (pe.psum_in_vld) begin
                            fwd_cnt <= fwd_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pe.out_f        = out_f_q;
    assign pe.out_w        = out_w_q;
    assign pe.out_a        = out_a_q;
    assign pe.psum_out     = psum_q;
    assign pe.psum_out_vld = psum_vld_q;
    assign pe.busy         = (state == ST_DRAIN);
    assign pe.ovf          = ovf_q;
endmodule
